gcd_arbiter: RTL and testbench

Round-robin controller that shares one GCD subtraction engine among `NREQ` requesters. It selects a requester, captures that requester's operands, and launches the engine. It then waits for the engine's DONE/ERROR and returns the result to the requester that was served. A cycle-count watchdog recovers a hung engine by resetting it. The block sits between the requester ports and a single GCD engine instance, and is the only agent that drives the engine's START, A, B and RST_N.

---
 rtl/gcd_arb_pkg.sv | 17 +
 rtl/gcd_arbiter_rr_pick.sv | 35 +++
 rtl/gcd_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_gcd_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_arb_pkg.sv
// Shared types and constants for the GCD engine arbiter.
package gcd_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    WAIT   = 3'd2,
    RESP   = 3'd3,
    FLUSH  = 3'd4
  } arb_state_t;

  localparam int unsigned FLUSH_CYCLES = 2;
  localparam int unsigned DEF_NREQ     = 4;
  localparam int unsigned DEF_W        = 8;
  localparam int unsigned DEF_TIMEOUT  = 600;

endpackage

// File: rtl/gcd_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import gcd_arb_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [NREQ-1:0] rot;
  logic [IW:0]     sum;

  // Rotate so bit 0 is the requester at ptr, then take the lowest set bit.
  always_comb begin
    rot = NREQ'({req, req} >> ptr);
    idx = '0;
    any = 1'b0;
    sum = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        sum = {1'b0, ptr} + (IW+1)'(i);
        if (sum >= (IW+1)'(NREQ)) begin
          sum = sum - (IW+1)'(NREQ);
        end
        idx = sum[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin owner of a single GCD engine: launches, collects results,
// and resets the engine through a watchdog when it hangs.
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int unsigned NREQ    = DEF_NREQ,
  parameter int unsigned W       = DEF_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ*W-1:0] REQ_A,
  input  logic [NREQ*W-1:0] REQ_B,
  output logic [NREQ-1:0] GNT,
  output logic [NREQ-1:0] RSP_VALID,
  output logic [W-1:0]    RSP_Y,
  output logic            RSP_ERR,
  output logic            RSP_TIMEOUT,
  output logic            ENG_START,
  output logic [W-1:0]    ENG_A,
  output logic [W-1:0]    ENG_B,
  output logic            ENG_RST_N,
  input  logic [W-1:0]    ENG_Y,
  input  logic            ENG_DONE,
  input  logic            ENG_ERROR
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam int unsigned FW = $clog2(FLUSH_CYCLES);

  arb_state_t      state_q, state_n;
  logic [IW-1:0]   ptr_q, ptr_n;
  logic [IW-1:0]   idx_q, idx_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [FW-1:0]   fcnt_q, fcnt_n;
  logic [NREQ-1:0] gnt_q, gnt_n;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_n;
  logic [W-1:0]    rsp_y_q, rsp_y_n;
  logic            rsp_err_q, rsp_err_n;
  logic            rsp_to_q, rsp_to_n;
  logic            eng_start_q, eng_start_n;
  logic [W-1:0]    eng_a_q, eng_a_n;
  logic [W-1:0]    eng_b_q, eng_b_n;
  logic            eng_rst_n_q, eng_rst_n_n;

  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [W-1:0]    a_arr [NREQ];
  logic [W-1:0]    b_arr [NREQ];

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    return NREQ'(1) << i;
  endfunction

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req (REQ),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      a_arr[i] = REQ_A[i*W +: W];
      b_arr[i] = REQ_B[i*W +: W];
    end
  end

  // Next-state and next-output logic; every output has a registered copy.
  always_comb begin
    state_n     = state_q;
    ptr_n       = ptr_q;
    idx_n       = idx_q;
    cnt_n       = cnt_q;
    fcnt_n      = fcnt_q;
    gnt_n       = gnt_q;
    rsp_valid_n = '0;
    rsp_y_n     = rsp_y_q;
    rsp_err_n   = rsp_err_q;
    rsp_to_n    = rsp_to_q;
    eng_start_n = 1'b0;
    eng_a_n     = eng_a_q;
    eng_b_n     = eng_b_q;
    eng_rst_n_n = 1'b1;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          idx_n       = pick_idx;
          eng_a_n     = a_arr[pick_idx];
          eng_b_n     = b_arr[pick_idx];
          gnt_n       = onehot(pick_idx);
          eng_start_n = 1'b1;
          state_n     = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        // A strobe on the expiry cycle still counts as a normal completion.
        if (ENG_DONE || ENG_ERROR) begin
          rsp_y_n     = ENG_Y;
          rsp_err_n   = ENG_ERROR;
          rsp_to_n    = 1'b0;
          rsp_valid_n = onehot(idx_q);
          state_n     = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          fcnt_n      = '0;
          eng_rst_n_n = 1'b0;
          state_n     = FLUSH;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
      end
      FLUSH: begin
        if (fcnt_q == FW'(FLUSH_CYCLES - 1)) begin
          rsp_y_n     = '0;
          rsp_err_n   = 1'b1;
          rsp_to_n    = 1'b1;
          rsp_valid_n = onehot(idx_q);
          state_n     = RESP;
        end else begin
          eng_rst_n_n = 1'b0;
          fcnt_n      = fcnt_q + FW'(1);
        end
      end
      RESP: begin
        gnt_n   = '0;
        ptr_n   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      fcnt_q      <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_y_q     <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
      eng_start_q <= 1'b0;
      eng_a_q     <= '0;
      eng_b_q     <= '0;
      eng_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      ptr_q       <= ptr_n;
      idx_q       <= idx_n;
      cnt_q       <= cnt_n;
      fcnt_q      <= fcnt_n;
      gnt_q       <= gnt_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_y_q     <= rsp_y_n;
      rsp_err_q   <= rsp_err_n;
      rsp_to_q    <= rsp_to_n;
      eng_start_q <= eng_start_n;
      eng_a_q     <= eng_a_n;
      eng_b_q     <= eng_b_n;
      eng_rst_n_q <= eng_rst_n_n;
    end
  end

  assign GNT         = gnt_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_Y       = rsp_y_q;
  assign RSP_ERR     = rsp_err_q;
  assign RSP_TIMEOUT = rsp_to_q;
  assign ENG_START   = eng_start_q;
  assign ENG_A       = eng_a_q;
  assign ENG_B       = eng_b_q;
  assign ENG_RST_N   = eng_rst_n_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter with a behavioural GCD engine model.
module tb_gcd_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int TO   = 16;

  logic              CLK = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   REQ;
  logic [NREQ*W-1:0] REQ_A, REQ_B;
  logic [NREQ-1:0]   GNT, RSP_VALID;
  logic [W-1:0]      RSP_Y;
  logic              RSP_ERR, RSP_TIMEOUT, ENG_START, ENG_RST_N;
  logic [W-1:0]      ENG_A, ENG_B, ENG_Y;
  logic              ENG_DONE, ENG_ERROR;

  gcd_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .GNT(GNT), .RSP_VALID(RSP_VALID), .RSP_Y(RSP_Y), .RSP_ERR(RSP_ERR),
    .RSP_TIMEOUT(RSP_TIMEOUT), .ENG_START(ENG_START), .ENG_A(ENG_A),
    .ENG_B(ENG_B), .ENG_RST_N(ENG_RST_N), .ENG_Y(ENG_Y),
    .ENG_DONE(ENG_DONE), .ENG_ERROR(ENG_ERROR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int           id;
    logic [W-1:0] y;
    bit           err;
    bit           to;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   mptr = 0;
  bit   eng_hang = 0;
  int   eng_lat = 0;
  int   strobe_cyc = -100;
  int   cont_n = 0;
  int   resp_seen = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] gcd_ref(input int a_in, input int b_in);
    int a = a_in;
    int b = b_in;
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return W'(a);
  endfunction

  function automatic int next_pick(input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++) begin
      if (m[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
    end
    return 0;
  endfunction

  function automatic void push_exp(input int id, input int a, input int b, input bit to);
    exp_t e;
    e.id = id;
    e.to = to;
    if (to || a == 0 || b == 0) begin
      e.y   = '0;
      e.err = 1'b1;
    end else begin
      e.y   = gcd_ref(a, b);
      e.err = 1'b0;
    end
    sb.push_back(e);
    mptr = (id + 1) % NREQ;
  endfunction

  // Batch: every requester in mask raises REQ once and holds until served.
  task automatic issue(input logic [NREQ-1:0] mask, input int a[NREQ], input int b[NREQ], input bit to);
    logic [NREQ-1:0] m = mask;
    int id;
    while (m != '0) begin
      id = next_pick(m);
      push_exp(id, a[id], b[id], to);
      m[id] = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (mask[i]) begin
        REQ_A[i*W +: W] = W'(a[i]);
        REQ_B[i*W +: W] = W'(b[i]);
      end
    end
    REQ = REQ | mask;
  endtask

  // Requesters keep REQ high continuously until n responses have been seen.
  task automatic issue_cont(input logic [NREQ-1:0] mask, input int a[NREQ], input int b[NREQ], input int n);
    int id;
    for (int k = 0; k < n; k++) begin
      id = next_pick(mask);
      push_exp(id, a[id], b[id], 1'b0);
    end
    for (int i = 0; i < NREQ; i++) begin
      REQ_A[i*W +: W] = W'(a[i]);
      REQ_B[i*W +: W] = W'(b[i]);
    end
    resp_seen = 0;
    cont_n    = n;
    REQ       = mask;
  endtask

  task automatic tick();
    @(negedge CLK);
    if (RSP_VALID != '0) begin
      resp_seen++;
      if (cont_n == 0) begin
        REQ = REQ & ~RSP_VALID;
      end else if (resp_seen >= cont_n) begin
        REQ    = '0;
        cont_n = 0;
      end
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((sb.size() != 0 || REQ != '0) && n < budget) begin
      tick();
      n++;
    end
    check("wait_bound_pending", 32'(sb.size()), 32'd0);
  endtask

  // Engine model: strobes eng_lat (or random) WAIT cycles after START.
  initial begin
    int           rem;
    logic [W-1:0] ea, eb;
    bit           busy;
    ENG_DONE = 1'b0; ENG_ERROR = 1'b0; ENG_Y = '0;
    rem = 0; ea = '0; eb = '0; busy = 1'b0;
    forever begin
      @(negedge CLK);
      ENG_DONE  = 1'b0;
      ENG_ERROR = 1'b0;
      if (!ENG_RST_N) begin
        busy = 1'b0;
      end else if (busy) begin
        rem--;
        if (rem == 0) begin
          busy       = 1'b0;
          strobe_cyc = cyc;
          if (ea == '0 || eb == '0) begin
            ENG_ERROR = 1'b1;
            ENG_Y     = '0;
          end else begin
            ENG_DONE = 1'b1;
            ENG_Y    = gcd_ref(int'(ea), int'(eb));
          end
        end
      end else if (ENG_START) begin
        ea   = ENG_A;
        eb   = ENG_B;
        busy = 1'b1;
        rem  = eng_hang ? 1000000 : (eng_lat > 0 ? eng_lat : int'($urandom_range(1, TO)));
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response is presented.
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && RSP_VALID != '0) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'(RSP_VALID), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_valid", 32'(RSP_VALID), 32'(1 << e.id));
        check("rsp_gnt", 32'(GNT), 32'(1 << e.id));
        check("rsp_y", 32'(RSP_Y), 32'(e.y));
        check("rsp_err", 32'(RSP_ERR), 32'(e.err));
        check("rsp_timeout", 32'(RSP_TIMEOUT), 32'(e.to));
        if (!e.to) check("rsp_latency", 32'(cyc - strobe_cyc), 32'd1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got running want finished");
    $fatal(1, "time limit");
  end

  initial begin
    int a[NREQ];
    int b[NREQ];
    int s, n;
    logic [NREQ-1:0] mask;

    RST = 1'b1; REQ = '0; REQ_A = '0; REQ_B = '0;
    for (int i = 0; i < NREQ; i++) begin a[i] = 0; b[i] = 0; end
    repeat (3) @(negedge CLK);
    check("reset_gnt", 32'(GNT), 32'd0);
    check("reset_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("reset_rsp_y", 32'(RSP_Y), 32'd0);
    check("reset_rsp_err", 32'(RSP_ERR), 32'd0);
    check("reset_rsp_timeout", 32'(RSP_TIMEOUT), 32'd0);
    check("reset_eng_start", 32'(ENG_START), 32'd0);
    check("reset_eng_a", 32'(ENG_A), 32'd0);
    check("reset_eng_b", 32'(ENG_B), 32'd0);
    check("reset_eng_rst_n", 32'(ENG_RST_N), 32'd0);
    RST = 1'b0;
    mptr = 0;
    tick();
    check("eng_rst_n_release", 32'(ENG_RST_N), 32'd1);

    // All four requesting continuously: 0,1,2,3,0.
    for (int i = 0; i < NREQ; i++) begin a[i] = 12; b[i] = 8; end
    issue_cont(4'b1111, a, b, 5);
    wait_done(200);

    // Single request with launch timing.
    a[0] = 48; b[0] = 18;
    issue(4'b0001, a, b, 1'b0);
    tick();
    check("launch_gnt", 32'(GNT), 32'h1);
    check("launch_eng_start", 32'(ENG_START), 32'd1);
    check("launch_eng_a", 32'(ENG_A), 32'd48);
    check("launch_eng_b", 32'(ENG_B), 32'd18);
    tick();
    check("eng_start_pulse", 32'(ENG_START), 32'd0);
    check("gnt_held_wait", 32'(GNT), 32'h1);
    wait_done(60);

    // Zero operand on requester 2.
    a[2] = 0; b[2] = 5;
    issue(4'b0100, a, b, 1'b0);
    wait_done(60);

    // Strobe on the last WAIT cycle beats the watchdog.
    eng_lat = TO;
    a[3] = 100; b[3] = 75;
    issue(4'b1000, a, b, 1'b0);
    wait_done(60);
    eng_lat = 0;

    // Hung engine: flush then timeout response.
    eng_hang = 1'b1;
    a[0] = 9; b[0] = 6;
    issue(4'b0001, a, b, 1'b1);
    n = 0;
    do begin tick(); n++; end while (!ENG_START && n < 10);
    check("hang_start_seen", 32'(ENG_START), 32'd1);
    s = cyc;
    n = 0;
    while (ENG_RST_N && n < 40) begin tick(); n++; end
    check("flush_begin_cycle", 32'(cyc - s), 32'(TO + 1));
    tick();
    check("flush_second_cycle", 32'(ENG_RST_N), 32'd0);
    tick();
    check("flush_end", 32'(ENG_RST_N), 32'd1);
    eng_hang = 1'b0;
    wait_done(40);

    // Randomized batches.
    for (int it = 0; it < 15; it++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) begin
        a[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
        b[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      end
      issue(mask, a, b, 1'b0);
      wait_done(40 * NREQ + 20);
    end

    // Leave ptr at 2, then reset in the middle of WAIT.
    a[1] = 21; b[1] = 14;
    issue(4'b0010, a, b, 1'b0);
    wait_done(60);
    eng_hang = 1'b1;
    issue(4'b0010, a, b, 1'b0);
    repeat (6) tick();
    RST = 1'b1;
    tick();
    check("midrst_gnt", 32'(GNT), 32'd0);
    check("midrst_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("midrst_rsp_y", 32'(RSP_Y), 32'd0);
    check("midrst_eng_start", 32'(ENG_START), 32'd0);
    check("midrst_eng_a", 32'(ENG_A), 32'd0);
    check("midrst_eng_rst_n", 32'(ENG_RST_N), 32'd0);
    sb.delete();
    REQ = '0;
    mptr = 0;
    eng_hang = 1'b0;
    RST = 1'b0;
    tick();
    check("midrst_release", 32'(ENG_RST_N), 32'd1);
    a[1] = 35; b[1] = 15; a[3] = 64; b[3] = 40;
    issue(4'b1010, a, b, 1'b0);
    wait_done(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
